max_pool_stream: RTL and testbench

//  Streaming non-overlapping PxP max-pooling stage placed directly downstream of the convolver.

---
 rtl/max_pool_stream.sv | 100 ++++++++++
 tb/tb_max_pool_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming non-overlapping PxP max pool over a row-major MxM stream using one line buffer.
// Optional ReLU ahead of pooling when RELU_EN is defined.
module max_pool_stream #(
  parameter int M = 8,
  parameter int P = 2,
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic         clk,
  input  logic         global_rst,
  input  logic         ce,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  input  logic         end_in,
  output logic [N-1:0] pool_op,
  output logic         valid_op,
  output logic         end_op
);
  localparam int W = M / P;
  localparam int CW = M > 1 ? $clog2(M) : 1;
  localparam int WI = W > 1 ? $clog2(W) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  if (P < 2 || P > M || Q >= N) begin : g_bad_cfg
    $error("max_pool_stream: invalid parameters");
  end
  logic [1:0] state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic signed [N-1:0] hmax_q, hmax_d, hmax_nx, din, pool_q, pool_d, lb_win;
  logic signed [N-1:0] lb_q [W];
  logic signed [N-1:0] lb_d [W];
  logic valid_q, valid_d, end_q, end_d;
  logic take, abort, in_win, last_c, last_r;
  logic [WI-1:0] wc;
  int unsigned cp, rp;
`ifdef RELU_EN
  assign din = data_in[N-1] ? '0 : data_in;
`else
  assign din = data_in;
`endif
  always_comb begin
    cp = 32'(col_q) % P;
    rp = 32'(row_q) % P;
    wc = WI'(32'(col_q) / P);
    in_win = 32'(col_q) < W * P && 32'(row_q) < W * P;
    last_c = 32'(col_q) == M - 1;
    last_r = 32'(row_q) == M - 1;
    abort = ce && state_q == RUN && end_in;
    take = ce && valid_in && state_q != DONE && !abort;
    hmax_nx = cp == 0 ? din : (din > hmax_q ? din : hmax_q);
    lb_win = lb_q[wc];
    lb_d = lb_q;
    hmax_d = hmax_q;
    col_d = col_q;
    row_d = row_q;
    state_d = state_q;
    pool_d = pool_q;
    valid_d = 1'b0;
    end_d = end_q || (ce && (state_q == DONE || abort));
    if (take) begin
      hmax_d = hmax_nx;
      col_d = last_c ? '0 : col_q + 1'b1;
      row_d = last_c ? (last_r ? '0 : row_q + 1'b1) : row_q;
      state_d = last_c && last_r ? DONE : RUN;
      // columns/rows beyond the last full window are consumed without touching the maxima
      if (in_win && cp == P - 1) begin
        if (rp == P - 1) begin
          pool_d = hmax_nx > lb_win ? hmax_nx : lb_win;
          valid_d = 1'b1;
        end else begin
          lb_d[wc] = (rp == 0 || hmax_nx > lb_win) ? hmax_nx : lb_win;
        end
      end
    end
    if (abort) state_d = DONE;
  end
  always_ff @(posedge clk) begin
    if (global_rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      hmax_q <= '0;
      pool_q <= '0;
      valid_q <= 1'b0;
      end_q <= 1'b0;
      lb_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      hmax_q <= hmax_d;
      pool_q <= pool_d;
      valid_q <= valid_d;
      end_q <= end_d;
      lb_q <= lb_d;
    end
  end
  assign pool_op = pool_q;
  assign valid_op = valid_q;
  assign end_op = end_q;
endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: scoreboard bench for max_pool_stream (M=8 and M=5 instances, P=2), honours RELU_EN.
module tb_max_pool_stream;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, v8 = 1'b0, v5 = 1'b0, e8 = 1'b0, e5 = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] po8, po5;
  logic vo8, vo5, eo8, eo5;
  int vecs = 0, errs = 0, sel = 0;
  int n [2];
  bit done [2];
  logic signed [15:0] fr [2][64];
  logic [15:0] q8 [$];
  logic [15:0] q5 [$];
`ifdef RELU_EN
  localparam logic [15:0] NEG_EXP = 16'h0000;
`else
  localparam logic [15:0] NEG_EXP = 16'hFC00;
`endif

  max_pool_stream #(.M(8), .P(2), .N(16), .Q(12)) dut8 (
    .clk(clk), .global_rst(rst), .ce(ce), .data_in(din), .valid_in(v8), .end_in(e8),
    .pool_op(po8), .valid_op(vo8), .end_op(eo8));
  max_pool_stream #(.M(5), .P(2), .N(16), .Q(12)) dut5 (
    .clk(clk), .global_rst(rst), .ce(ce), .data_in(din), .valid_in(v5), .end_in(e5),
    .pool_op(po5), .valid_op(vo5), .end_op(eo5));

  always #5 clk = ~clk;

  function automatic logic signed [15:0] relu(input logic [15:0] d);
`ifdef RELU_EN
    return d[15] ? 16'sd0 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference: keep the frame as an array, emit the max of each PxP window when its last sample arrives
  task automatic model(input bit v, input logic [15:0] d, input bit e);
    int mx, r, c;
    logic signed [15:0] w;
    mx = sel ? 5 : 8;
    if (done[sel]) return;
    if (e && n[sel] > 0) begin
      done[sel] = 1'b1;
      return;
    end
    if (!v) return;
    fr[sel][n[sel]] = relu(d);
    r = n[sel] / mx;
    c = n[sel] % mx;
    n[sel]++;
    if (n[sel] == mx * mx) done[sel] = 1'b1;
    if (r % 2 == 1 && c % 2 == 1 && r < mx / 2 * 2 && c < mx / 2 * 2) begin
      w = fr[sel][r * mx + c];
      for (int i = r - 1; i <= r; i++)
        for (int j = c - 1; j <= c; j++)
          if (fr[sel][i * mx + j] > w) w = fr[sel][i * mx + j];
      if (sel != 0) q5.push_back(w);
      else q8.push_back(w);
    end
  endtask

  task automatic cyc(input bit c, input bit v, input logic [15:0] d, input bit e);
    ce = c;
    din = d;
    v8 = v && sel == 0;
    v5 = v && sel == 1;
    e8 = e && sel == 0;
    e5 = e && sel == 1;
    if (!rst && c) model(v, d, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b1, 16'h7abc, 1'b0);
    rst = 1'b0;
    n = '{0, 0};
    done = '{1'b0, 1'b0};
  endtask

  always @(negedge clk) begin
    if (vo8) begin
      if (q8.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL pool8_extra: got %h, want no output", po8);
      end else chk("pool8", po8, q8.pop_front());
    end
    if (vo5) begin
      if (q5.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL pool5_extra: got %h, want no output", po5);
      end else chk("pool5", po5, q5.pop_front());
    end
  end

  initial begin
    int g [3];
    logic [15:0] d;
    int guard;
    do_reset();
    chk("rst_pool", po8, 16'h0);
    chk("rst_valid", 16'(vo8), 16'h0);
    chk("rst_end", 16'(eo8), 16'h0);
    chk("rst_end5", 16'(eo5), 16'h0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 16'(i), 1'b0);
    chk("ramp_last", po8, 16'd63);
    chk("ramp_last_valid", 16'(vo8), 16'h1);
    chk("ramp_end_early", 16'(eo8), 16'h0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk("ramp_end", 16'(eo8), 16'h1);
    do_reset();
    for (int k = 0; k < 3; k++) g[k] = int'($urandom_range(0, 63));
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 3; k++)
        if (g[k] == i) cyc(1'b0, 1'b1, 16'($urandom), 1'b1);
      cyc(1'b1, 1'b1, 16'(i), 1'b0);
      cyc(1'b1, 1'b0, 16'($urandom), 1'b0);
    end
    chk("gap_end", 16'(eo8), 16'h1);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      d = i == 0 ? 16'hF000 : i == 1 ? 16'hF800 : i == 8 ? 16'hE000 : i == 9 ? 16'hFC00 : 16'($urandom);
      cyc(1'b1, 1'b1, d, 1'b0);
      if (i == 9) chk("neg_window", po8, NEG_EXP);
    end
    do_reset();
    sel = 1;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b1, 1'b1, 16'(i), 1'b0);
      if (i == 23) chk("rem_end_early", 16'(eo5), 16'h0);
    end
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rem_end", 16'(eo5), 16'h1);
    sel = 0;
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 16'($urandom), 1'b0);
    do_reset();
    chk("midrst_end", 16'(eo8), 16'h0);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b1, 16'(i), 1'b0);
      if (i == 62) chk("midrst_end_early", 16'(eo8), 16'h0);
    end
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk("midrst_end_final", 16'(eo8), 16'h1);
    do_reset();
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 16'(i), 1'b0);
    cyc(1'b1, 1'b0, 16'h0, 1'b1);
    chk("trunc_end", 16'(eo8), 16'h1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 16'(100 + i), 1'b0);
    chk("trunc_end_sticky", 16'(eo8), 16'h1);
    do_reset();
    for (int f = 0; f < 4; f++) begin
      sel = f % 2;
      guard = 0;
      while (!done[sel] && guard < 2000) begin
        cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, 16'($urandom),
            f == 3 && $urandom_range(0, 99) == 0);
        guard++;
      end
      cyc(1'b1, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b0);
      chk("rand_end", 16'(sel != 0 ? eo5 : eo8), 16'h1);
      do_reset();
    end
    sel = 0;
    repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b0);
    chk("q8_drained", 16'(q8.size()), 16'h0);
    chk("q5_drained", 16'(q5.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
